// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: opcodes, funct codes,
// ALUControl codes (also used by the ALU) and FSM state numbering.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_MUL = 6'b011000;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b100;
    localparam logic [2:0] ALU_MUL = 3'b101;
    localparam logic [2:0] ALU_SLT = 3'b110;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BEQ     = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11,
        S_BNE     = 4'd12
    } state_t;

endpackage

// File: rtl/mips_alu_decoder.sv
// Combinational ALU decoder: ALUOp plus Funct to ALUControl. FunctValid flags
// whether Funct is a supported R-type operation, independent of ALUOp.
module mips_alu_decoder
    import mips_ctrl_pkg::*;
#(
    parameter int FW  = 6,
    parameter int ACW = 3
) (
    input  alu_op_t         alu_op,
    input  logic [FW-1:0]   funct,
    output logic [ACW-1:0]  alu_control,
    output logic            funct_valid
);

    logic [ACW-1:0] funct_ctrl;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        funct_ctrl  = ALU_ADD;
        funct_valid = 1'b1;
        case (funct)
            FN_ADD:  funct_ctrl = ALU_ADD;
            FN_SUB:  funct_ctrl = ALU_SUB;
            FN_AND:  funct_ctrl = ALU_AND;
            FN_OR:   funct_ctrl = ALU_OR;
            FN_MUL:  funct_ctrl = ALU_MUL;
            FN_SLT:  funct_ctrl = ALU_SLT;
            default: funct_valid = 1'b0;
        endcase
    end

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_SUB:   alu_control = ALU_SUB;
            ALUOP_FUNCT: alu_control = funct_ctrl;
            default:     alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM (Moore). Define MIPS_CTRL_BNE_EN to add bne support;
// without it bne retires as a NOP.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int OPW = 6,
    parameter int FW  = 6,
    parameter int ACW = 3
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [OPW-1:0]  Opcode,
    input  logic [FW-1:0]   Funct,
    input  logic            Zero,
    output logic            IRWrite,
    output logic            PCEn,
    output logic            MemWrite,
    output logic            IorD,
    output logic            RegWrite,
    output logic            RegDst,
    output logic            MemtoReg,
    output logic            ALUSrcA,
    output logic [1:0]      ALUSrcB,
    output logic [1:0]      PCSrc,
    output logic [ACW-1:0]  ALUControl,
    output logic [3:0]      State
);

    state_t  state, state_next;
    alu_op_t alu_op;
    logic    pc_write, branch, branch_ne, funct_valid;

    mips_alu_decoder #(.FW(FW), .ACW(ACW)) u_alu_decoder (
        .alu_op      (alu_op),
        .funct       (Funct),
        .alu_control (ALUControl),
        .funct_valid (funct_valid)
    );

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= S_FETCH;
        else     state <= state_next;
    end

    always_comb begin
        state_next = S_FETCH;
        case (state)
            S_FETCH:  state_next = S_DECODE;
            S_DECODE: begin
                case (Opcode)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYPE:     state_next = funct_valid ? S_EXECUTE : S_FETCH;
                    OP_BEQ:       state_next = S_BEQ;
                    OP_ADDI:      state_next = S_ADDIEX;
                    OP_J:         state_next = S_JUMP;
`ifdef MIPS_CTRL_BNE_EN
                    OP_BNE:       state_next = S_BNE;
`endif
                    default:      state_next = S_FETCH;
                endcase
            end
            S_MEMADR:  state_next = (Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   state_next = S_MEMWB;
            S_EXECUTE: state_next = S_ALUWB;
            S_ADDIEX:  state_next = S_ADDIWB;
            default:   state_next = S_FETCH;
        endcase
    end

    always_comb begin
        IRWrite   = 1'b0;
        pc_write  = 1'b0;
        MemWrite  = 1'b0;
        IorD      = 1'b0;
        RegWrite  = 1'b0;
        RegDst    = 1'b0;
        MemtoReg  = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        PCSrc     = 2'b00;
        alu_op    = ALUOP_ADD;
        branch    = 1'b0;
        branch_ne = 1'b0;
        case (state)
            S_FETCH: begin
                IRWrite  = 1'b1;
                pc_write = 1'b1;
                ALUSrcB  = 2'b01;
            end
            S_DECODE: ALUSrcB = 2'b11;
            S_MEMADR, S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMRD: IorD = 1'b1;
            S_MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            S_MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            S_EXECUTE: begin
                ALUSrcA = 1'b1;
                alu_op  = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            S_ADDIWB: RegWrite = 1'b1;
            S_BEQ: begin
                ALUSrcA = 1'b1;
                alu_op  = ALUOP_SUB;
                PCSrc   = 2'b01;
                branch  = 1'b1;
            end
`ifdef MIPS_CTRL_BNE_EN
            S_BNE: begin
                ALUSrcA   = 1'b1;
                alu_op    = ALUOP_SUB;
                PCSrc     = 2'b01;
                branch_ne = 1'b1;
            end
`endif
            S_JUMP: begin
                PCSrc    = 2'b10;
                pc_write = 1'b1;
            end
            default: ;
        endcase
    end

    assign PCEn  = pc_write | (branch & Zero) | (branch_ne & ~Zero);
    assign State = state;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed self-checking bench for mips_multicycle_ctrl; expected values are hand-derived.
module tb_mips_multicycle_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic [5:0] Opcode, Funct;
    logic       Zero;
    logic       IRWrite, PCEn, MemWrite, IorD, RegWrite, RegDst, MemtoReg, ALUSrcA;
    logic [1:0] ALUSrcB, PCSrc;
    logic [2:0] ALUControl;
    logic [3:0] State;

    int vectors = 0;
    int miscompares = 0;

    mips_multicycle_ctrl dut (
        .CLK(CLK), .RST(RST), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
        .IRWrite(IRWrite), .PCEn(PCEn), .MemWrite(MemWrite), .IorD(IorD),
        .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc),
        .ALUControl(ALUControl), .State(State)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Packs the write strobes so one comparison proves none of them fired.
    function automatic logic [7:0] writes();
        return {4'b0, IRWrite, MemWrite, RegWrite, PCEn};
    endfunction

    logic [5:0] functs [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b011000, 6'b101010};
    logic [2:0] ctrls  [6] = '{3'b010, 3'b100, 3'b000, 3'b001, 3'b101, 3'b110};

    initial begin
        RST = 1'b1; Opcode = 6'b100011; Funct = 6'b0; Zero = 1'b0;
        #2;
        chk("rst_state",    {4'b0, State}, 8'd0);
        chk("rst_irwrite",  {7'b0, IRWrite}, 8'd1);
        chk("rst_pcen",     {7'b0, PCEn}, 8'd1);
        chk("rst_srcb",     {6'b0, ALUSrcB}, 8'd1);
        chk("rst_aluctl",   {5'b0, ALUControl}, 8'd2);
        chk("rst_others",   {MemWrite, IorD, RegWrite, RegDst, MemtoReg, ALUSrcA, PCSrc}, 8'd0);
        @(negedge CLK); RST = 1'b0;

        // lw: 0,1,2,3,4,0
        step(); chk("lw_decode", {4'b0, State}, 8'd1);
        chk("lw_decode_srcb", {6'b0, ALUSrcB}, 8'd3);
        step(); chk("lw_memadr", {4'b0, State}, 8'd2);
        chk("lw_memadr_src", {5'b0, ALUSrcA, ALUSrcB}, 8'b110);
        step(); chk("lw_memrd", {4'b0, State}, 8'd3);
        chk("lw_memrd_iord", {7'b0, IorD}, 8'd1);
        chk("lw_memrd_wr", writes(), 8'd0);
        step(); chk("lw_memwb", {4'b0, State}, 8'd4);
        chk("lw_memwb_ctl", {6'b0, MemtoReg, RegWrite}, 8'b11);
        step(); chk("lw_fetch", {4'b0, State}, 8'd0);

        // sw: 0,1,2,5,0
        Opcode = 6'b101011;
        step(); step(); chk("sw_memadr", {4'b0, State}, 8'd2);
        step(); chk("sw_memwr", {4'b0, State}, 8'd5);
        chk("sw_memwr_ctl", {6'b0, IorD, MemWrite}, 8'b11);
        chk("sw_memwr_nowb", {7'b0, RegWrite}, 8'd0);
        step(); chk("sw_fetch", {4'b0, State}, 8'd0);

        // R-type over every supported funct
        Opcode = 6'b000000;
        for (int i = 0; i < 6; i++) begin
            Funct = functs[i];
            step(); chk("r_decode", {4'b0, State}, 8'd1);
            step(); chk("r_execute", {4'b0, State}, 8'd6);
            chk("r_aluctl", {5'b0, ALUControl}, {5'b0, ctrls[i]});
            chk("r_exec_src", {5'b0, ALUSrcA, ALUSrcB}, 8'b100);
            step(); chk("r_aluwb", {4'b0, State}, 8'd7);
            chk("r_aluwb_ctl", {6'b0, RegDst, RegWrite}, 8'b11);
            step(); chk("r_fetch", {4'b0, State}, 8'd0);
        end

        // unsupported funct retires as NOP
        Funct = 6'b000111;
        step(); chk("rbad_decode", {4'b0, State}, 8'd1);
        chk("rbad_decode_wr", writes(), 8'd0);
        step(); chk("rbad_fetch", {4'b0, State}, 8'd0);

        // beq taken / not taken
        Opcode = 6'b000100; Zero = 1'b1;
        step(); step(); chk("beq_state", {4'b0, State}, 8'd8);
        chk("beq_taken_pcen", {7'b0, PCEn}, 8'd1);
        chk("beq_pcsrc", {6'b0, PCSrc}, 8'd1);
        chk("beq_aluctl", {5'b0, ALUControl}, 8'd4);
        Zero = 1'b0; #1;
        chk("beq_nt_pcen", {7'b0, PCEn}, 8'd0);
        step(); chk("beq_fetch", {4'b0, State}, 8'd0);

        // addi: 0,1,9,10,0
        Opcode = 6'b001000;
        step(); step(); chk("addi_ex", {4'b0, State}, 8'd9);
        chk("addi_ex_src", {5'b0, ALUSrcA, ALUSrcB}, 8'b110);
        step(); chk("addi_wb", {4'b0, State}, 8'd10);
        chk("addi_wb_ctl", {6'b0, RegDst, RegWrite}, 8'b01);
        step(); chk("addi_fetch", {4'b0, State}, 8'd0);

        // j
        Opcode = 6'b000010;
        step(); step(); chk("j_state", {4'b0, State}, 8'd11);
        chk("j_ctl", {5'b0, PCEn, PCSrc}, 8'b110);
        step(); chk("j_fetch", {4'b0, State}, 8'd0);

        // unknown opcode: 2-cycle NOP
        Opcode = 6'b111111;
        step(); chk("nop_decode", {4'b0, State}, 8'd1);
        chk("nop_wr", writes(), 8'd0);
        step(); chk("nop_fetch", {4'b0, State}, 8'd0);

        // bne
        Opcode = 6'b000101; Zero = 1'b0;
        step(); chk("bne_decode", {4'b0, State}, 8'd1);
        step();
`ifdef MIPS_CTRL_BNE_EN
        chk("bne_state", {4'b0, State}, 8'd12);
        chk("bne_taken", {5'b0, PCEn, PCSrc}, 8'b101);
        Zero = 1'b1; #1;
        chk("bne_nt_pcen", {7'b0, PCEn}, 8'd0);
        step();
`endif
        chk("bne_fetch", {4'b0, State}, 8'd0);

        // asynchronous reset in the middle of MEMRD
        Opcode = 6'b100011; Zero = 1'b0;
        step(); step(); step(); chk("arst_memrd", {4'b0, State}, 8'd3);
        #2 RST = 1'b1; #1;
        chk("arst_state", {4'b0, State}, 8'd0);
        chk("arst_fetch_out", {IRWrite, PCEn, ALUSrcB, 1'b0, ALUControl}, 8'b1101_0010);
        chk("arst_nowb", {6'b0, RegWrite, MemtoReg}, 8'd0);
        step(); chk("arst_hold", {4'b0, State}, 8'd0);
        @(negedge CLK); RST = 1'b0;
        step(); chk("arst_resume", {4'b0, State}, 8'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
